// File: rtl/face_render_pkg.sv
// Shared state encoding and width helpers for the face render sequencer.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package face_render_pkg;

    // Sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        DRAW      = 3'd3,
        NEXT      = 3'd4,
        SWAP_WAIT = 3'd5
    } render_state_t;

    // Width of the feature index field; never narrower than one bit so a
    // single-feature build still has a legal index register.
    function automatic int feat_bits(input int num_features);
        return (num_features > 1) ? $clog2(num_features) : 1;
    endfunction

    // Framebuffer address = {bank, feature index, pixel address}.
    function automatic int fb_addr_size(input int num_features, input int address_size);
        return 1 + feat_bits(num_features) + address_size;
    endfunction

endpackage

// File: rtl/render_stream_mux.sv
// Registered N:1 select of the active constructor's pixel stream onto the framebuffer port.
// Latency: 1 cycle from selected valid/addr/data to o_we/o_addr/o_data.
// Backpressure: none; the framebuffer accepts every beat, non-selected streams are discarded.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_draw              forwarding enabled (sequencer is in DRAW)
//   i_back_bank         bank currently being rendered into
//   i_idx               active feature index
//   i_valid/addr/data   per-feature pixel streams
//   o_we/o_addr/o_data  framebuffer write port; addr/data hold when o_we is low
module render_stream_mux
    import face_render_pkg::*;
#(
    parameter int NUM_FEATURES = 3,
    parameter int ADDRESS_SIZE = 11,
    parameter int PIXEL_SIZE   = 12,
    parameter int FEAT_BITS    = feat_bits(NUM_FEATURES),
    parameter int FB_ADDR_SIZE = 1 + FEAT_BITS + ADDRESS_SIZE
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_draw,
    input  logic                                      i_back_bank,
    input  logic [FEAT_BITS-1:0]                      i_idx,
    input  logic [NUM_FEATURES-1:0]                   i_valid,
    input  logic [NUM_FEATURES-1:0][ADDRESS_SIZE-1:0] i_addr,
    input  logic [NUM_FEATURES-1:0][PIXEL_SIZE-1:0]   i_data,
    output logic                                      o_we,
    output logic [FB_ADDR_SIZE-1:0]                   o_addr,
    output logic [PIXEL_SIZE-1:0]                     o_data
);

    logic                    w_sel_vld;
    logic [ADDRESS_SIZE-1:0] w_sel_addr;
    logic [PIXEL_SIZE-1:0]   w_sel_data;
    logic                    w_fwd;

    logic                    r_we;
    logic [FB_ADDR_SIZE-1:0] r_addr;
    logic [PIXEL_SIZE-1:0]   r_data;

    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            if (i_idx == FEAT_BITS'(i)) begin
                w_sel_vld  = i_valid[i];
                w_sel_addr = i_addr[i];
                w_sel_data = i_data[i];
            end
        end
    end

    // Only the active feature, and only while drawing, reaches the port.
    assign w_fwd = i_draw && w_sel_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_fwd;
            // Address/data only move on a real write so the port holds
            // the last written beat while idle.
            if (w_fwd) begin
                r_addr <= {i_back_bank, i_idx, w_sel_addr};
                r_data <= w_sel_data;
            end
        end
    end

    assign o_we   = r_we;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/face_render_sequencer.sv
// Runs each face-feature constructor in turn per frame request and renders into the back bank, swapping on vsync.
// Latency: pixel path 1 cycle; start pulse 1 cycle after leaving IDLE; swap on the first vsync after the last feature.
// Backpressure: none on pixels; one frame request is queued while busy, later ones are dropped and counted.
//
// Ports:
//   clk_in, rst_n_in          clock, async active-low reset
//   frame_req_in, vsync_in    render request pulse, scan-out frame boundary pulse
//   feature_start_out         one-hot start pulse to the constructors
//   feature_busy/addr/data/valid_in   per-constructor status and pixel streams
//   fb_we/addr/data_out       framebuffer write port
//   display_bank_out          bank being scanned out
//   frame_done_out            pulse on the bank swap cycle
//   busy_out                  sequencer not idle
//   timeout_err_out           sticky constructor timeout flag
//   drop_count_out            saturating count of dropped requests
module face_render_sequencer
    import face_render_pkg::*;
#(
    parameter  int NUM_FEATURES   = 3,
    parameter  int NUM_BLOCK_ROWS = 16,
    parameter  int NUM_PIXELS     = 128,
    parameter  int LOG_POWER_MOD  = 4,
    parameter  int START_TIMEOUT  = 64,
    parameter  int DRAW_TIMEOUT   = 4096,
    localparam int ADDRESS_SIZE   = $clog2(NUM_BLOCK_ROWS * NUM_PIXELS),
    localparam int PIXEL_SIZE     = 3 * LOG_POWER_MOD,
    localparam int FEAT_BITS      = feat_bits(NUM_FEATURES),
    localparam int FB_ADDR_SIZE   = fb_addr_size(NUM_FEATURES, ADDRESS_SIZE)
) (
    input  logic                                      clk_in,
    input  logic                                      rst_n_in,
    input  logic                                      frame_req_in,
    input  logic                                      vsync_in,
    output logic [NUM_FEATURES-1:0]                   feature_start_out,
    input  logic [NUM_FEATURES-1:0]                   feature_busy_in,
    input  logic [NUM_FEATURES-1:0][ADDRESS_SIZE-1:0] feature_addr_in,
    input  logic [NUM_FEATURES-1:0][PIXEL_SIZE-1:0]   feature_data_in,
    input  logic [NUM_FEATURES-1:0]                   feature_valid_in,
    output logic                                      fb_we_out,
    output logic [FB_ADDR_SIZE-1:0]                   fb_addr_out,
    output logic [PIXEL_SIZE-1:0]                     fb_data_out,
    output logic                                      display_bank_out,
    output logic                                      frame_done_out,
    output logic                                      busy_out,
    output logic                                      timeout_err_out,
    output logic [7:0]                                drop_count_out
);

    // One timer serves both the start and draw watchdogs.
    localparam int TMR_MAX = (DRAW_TIMEOUT > START_TIMEOUT) ? DRAW_TIMEOUT : START_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    render_state_t          r_state;
    render_state_t          w_state_nxt;
    logic [FEAT_BITS-1:0]   r_idx;
    logic [TMR_W-1:0]       r_timer;
    logic                   r_pending;
    logic [7:0]             r_drop;
    logic                   r_err;
    logic                   r_bank;

    logic [NUM_FEATURES-1:0] w_start;
    logic                    w_busy_sel;
    logic                    w_draw;
    logic                    w_clr_pend;
    logic                    w_idx_clr;
    logic                    w_idx_inc;
    logic                    w_tmr_clr;
    logic                    w_tmr_inc;
    logic                    w_set_err;
    logic                    w_swap;
    logic                    w_back_bank;

    always_comb begin
        w_busy_sel = 1'b0;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            if (r_idx == FEAT_BITS'(i)) begin
                w_busy_sel = feature_busy_in[i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = '0;
        w_draw      = 1'b0;
        w_clr_pend  = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_tmr_clr   = 1'b0;
        w_tmr_inc   = 1'b0;
        w_set_err   = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_req_in || r_pending) begin
                    w_clr_pend  = 1'b1;
                    w_idx_clr   = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                for (int i = 0; i < NUM_FEATURES; i++) begin
                    w_start[i] = (r_idx == FEAT_BITS'(i));
                end
                w_tmr_clr   = 1'b1;
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (w_busy_sel) begin
                    // Restart the timer so DRAW measures busy time only.
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = DRAW;
                end else if (r_timer == TMR_W'(START_TIMEOUT - 1)) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = NEXT;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            DRAW: begin
                w_draw = 1'b1;
                if (!w_busy_sel) begin
                    w_state_nxt = NEXT;
                end else if (r_timer == TMR_W'(DRAW_TIMEOUT - 1)) begin
                    // Hung constructor: abandon it, keep the frame moving.
                    w_set_err   = 1'b1;
                    w_state_nxt = NEXT;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            NEXT: begin
                if (r_idx == FEAT_BITS'(NUM_FEATURES - 1)) begin
                    w_state_nxt = SWAP_WAIT;
                end else begin
                    w_idx_inc   = 1'b1;
                    w_state_nxt = START;
                end
            end
            SWAP_WAIT: begin
                if (vsync_in) begin
                    w_swap      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_idx     <= '0;
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_drop    <= '0;
            r_err     <= 1'b0;
            r_bank    <= 1'b0;
        end else begin
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + FEAT_BITS'(1);
            end

            if (w_tmr_clr) begin
                r_timer <= '0;
            end else if (w_tmr_inc) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (w_set_err) begin
                r_err <= 1'b1;
            end

            if (w_swap) begin
                r_bank <= ~r_bank;
            end

            // A request arriving in IDLE is consumed directly; elsewhere
            // the first one is remembered and any more are counted as drops.
            // This also covers a request landing on the swap cycle.
            if (w_clr_pend) begin
                r_pending <= 1'b0;
            end else if (frame_req_in && (r_state != IDLE)) begin
                if (!r_pending) begin
                    r_pending <= 1'b1;
                end else if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end
        end
    end

    assign w_back_bank = ~r_bank;

    render_stream_mux #(
        .NUM_FEATURES (NUM_FEATURES),
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .PIXEL_SIZE   (PIXEL_SIZE),
        .FEAT_BITS    (FEAT_BITS),
        .FB_ADDR_SIZE (FB_ADDR_SIZE)
    ) u_stream_mux (
        .i_clk       (clk_in),
        .i_rst_n     (rst_n_in),
        .i_draw      (w_draw),
        .i_back_bank (w_back_bank),
        .i_idx       (r_idx),
        .i_valid     (feature_valid_in),
        .i_addr      (feature_addr_in),
        .i_data      (feature_data_in),
        .o_we        (fb_we_out),
        .o_addr      (fb_addr_out),
        .o_data      (fb_data_out)
    );

    assign feature_start_out = w_start;
    assign display_bank_out  = r_bank;
    assign frame_done_out    = w_swap;
    assign busy_out          = (r_state != IDLE);
    assign timeout_err_out   = r_err;
    assign drop_count_out    = r_drop;

endmodule
